dmx_rx: RTL and testbench

//  DMX512 receiver: the receive end of the DMX link driven by the team's DMX transmitter.

---
 rtl/dmx_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_dmx_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx_rx.sv
// DMX512 receiver: synchronises the Rx line, detects BREAK/MAB, deserialises
// 8N2 slots, checks the start code and writes data slots through a byte port.
//
// Write port: slot_we is a one-clk strobe with no back-pressure. slot_addr and
// slot_data are valid in the strobe cycle and hold until the next strobe; the
// parent must take the byte in that cycle.
module dmx_rx #(
    parameter int          CLK_FREQ     = 12000000,
    parameter int          BAUD_RATE    = 250000,
    parameter int          BREAK_MIN_US = 88,
    parameter logic [7:0]  START_CODE   = 8'h00,
    parameter int          MAX_SLOTS    = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx,
    output logic       slot_we,
    output logic [8:0] slot_addr,
    output logic [7:0] slot_data,
    output logic [7:0] start_code,
    output logic       frame_start,
    output logic       frame_done,
    output logic [9:0] slot_count,
    output logic       err_framing,
    output logic [2:0] dbg_state
);

    localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;
    localparam int BREAK_CLKS = (CLK_FREQ / 1000000) * BREAK_MIN_US;
    localparam int LOW_W      = $clog2(BREAK_CLKS + 1);
    localparam int BIT_W      = $clog2(BIT_CLKS);

    localparam logic [LOW_W-1:0] BREAK_MAX = LOW_W'(BREAK_CLKS);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_CLKS - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(BIT_CLKS / 2 - 1);
    localparam logic [9:0]       MAX_IDX   = 10'(MAX_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BREAK = 3'd1,
        S_MAB   = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_SLOT  = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    logic             rx_meta_q;
    logic             rxs_q;
    logic [LOW_W-1:0] low_cnt_q;
    logic [LOW_W-1:0] low_cnt_d;
    logic             break_hit;

    state_t           state_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [9:0]       byte_idx_q;
    logic             frame_open_q;
    logic             susp_q;

    logic             slot_we_q;
    logic [8:0]       slot_addr_q;
    logic [7:0]       slot_data_q;
    logic [7:0]       start_code_q;
    logic             frame_start_q;
    logic             frame_done_q;
    logic [9:0]       slot_count_q;
    logic             err_framing_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Consecutive-low counter, saturating at the break length.
    always_comb begin
        low_cnt_d = low_cnt_q;
        if (!enable || rxs_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != BREAK_MAX) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end
    end

    // Break fires once, on the clk the counter reaches the break length.
    assign break_hit = (low_cnt_d == BREAK_MAX) && (low_cnt_q != BREAK_MAX);

    // Register the low counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_q <= '0;
        end else begin
            low_cnt_q <= low_cnt_d;
        end
    end

    // Receive FSM with registered strobes and slot port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_idx_q    <= '0;
            frame_open_q  <= 1'b0;
            susp_q        <= 1'b0;
            slot_we_q     <= 1'b0;
            slot_addr_q   <= '0;
            slot_data_q   <= '0;
            start_code_q  <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            slot_count_q  <= '0;
            err_framing_q <= 1'b0;
        end else begin
            slot_we_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_framing_q <= 1'b0;
            if (!enable) begin
                state_q      <= S_IDLE;
                frame_open_q <= 1'b0;
                susp_q       <= 1'b0;
            end else if (break_hit) begin
                // Break overrides any state. slot_count is cleared in BREAK,
                // so the frame_done clk still shows the closing frame's count.
                state_q      <= S_BREAK;
                susp_q       <= 1'b0;
                frame_open_q <= 1'b0;
                byte_idx_q   <= '0;
                if (frame_open_q && (slot_count_q != '0)) begin
                    frame_done_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // An all-zero byte with a low stop bit was taken as the
                        // start of a break; if the line rises first it was a
                        // genuine framing error.
                        if (susp_q && rxs_q) begin
                            susp_q        <= 1'b0;
                            frame_open_q  <= 1'b0;
                            err_framing_q <= 1'b1;
                        end
                    end
                    S_BREAK: begin
                        slot_count_q <= '0;
                        if (rxs_q) begin
                            state_q <= S_MAB;
                        end
                    end
                    S_MAB, S_GAP: begin
                        if (!rxs_q) begin
                            state_q   <= S_START;
                            bit_cnt_q <= HALF_LAST;
                        end
                    end
                    S_START: begin
                        if (bit_cnt_q == '0) begin
                            if (rxs_q) begin
                                state_q      <= S_IDLE;
                                frame_open_q <= 1'b0;
                            end else begin
                                state_q   <= S_DATA;
                                bit_cnt_q <= BIT_LAST;
                                bit_idx_q <= '0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (bit_cnt_q == '0) begin
                            shift_q   <= {rxs_q, shift_q[7:1]};
                            bit_cnt_q <= BIT_LAST;
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_cnt_q == '0) begin
                            if (rxs_q) begin
                                state_q <= S_SLOT;
                            end else if (shift_q == 8'h00) begin
                                state_q <= S_IDLE;
                                susp_q  <= 1'b1;
                            end else begin
                                state_q       <= S_IDLE;
                                frame_open_q  <= 1'b0;
                                err_framing_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                    S_SLOT: begin
                        byte_idx_q <= byte_idx_q + 1'b1;
                        if (byte_idx_q == '0) begin
                            start_code_q <= shift_q;
                            if (shift_q == START_CODE) begin
                                frame_start_q <= 1'b1;
                                frame_open_q  <= 1'b1;
                                state_q       <= S_GAP;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            slot_we_q    <= 1'b1;
                            slot_addr_q  <= 9'(byte_idx_q - 10'd1);
                            slot_data_q  <= shift_q;
                            slot_count_q <= byte_idx_q;
                            if (byte_idx_q == MAX_IDX) begin
                                frame_done_q <= 1'b1;
                                frame_open_q <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                state_q <= S_GAP;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign slot_we     = slot_we_q;
    assign slot_addr   = slot_addr_q;
    assign slot_data   = slot_data_q;
    assign start_code  = start_code_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign slot_count  = slot_count_q;
    assign err_framing = err_framing_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmx_rx.sv
// Bench for dmx_rx, run at a 2 MHz clock so a full 513-slot frame stays short:
// 8 clks per bit, break threshold 176 clks, 2 clks per microsecond.
`timescale 1ns/1ps
module tb_dmx_rx;

    localparam int CLK_FREQ = 2000000;
    localparam int BIT      = 8;
    localparam int US       = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       rx = 1'b1;
    logic       slot_we;
    logic [8:0] slot_addr;
    logic [7:0] slot_data;
    logic [7:0] start_code;
    logic       frame_start;
    logic       frame_done;
    logic [9:0] slot_count;
    logic       err_framing;
    logic [2:0] dbg_state;

    logic [16:0] exp_q[$];
    logic [9:0]  done_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int cnt_we = 0;
    int cnt_fs = 0;
    int cnt_fd = 0;
    int cnt_err = 0;

    dmx_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx),
        .slot_we(slot_we), .slot_addr(slot_addr), .slot_data(slot_data),
        .start_code(start_code), .frame_start(frame_start), .frame_done(frame_done),
        .slot_count(slot_count), .err_framing(err_framing), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #250 clk = ~clk;

    // Monitor / scoreboard: compare writes and frame ends against expectations
    always @(negedge clk) begin
        logic [16:0] e;
        logic [9:0]  d;
        if (slot_we) begin
            cnt_we++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL slot_write_unexpected got addr=%0d data=%02h expected none", slot_addr, slot_data);
            end else begin
                e = exp_q.pop_front();
                if ({slot_addr, slot_data} !== e)
                    $display("FAIL slot_write got addr=%0d data=%02h expected addr=%0d data=%02h",
                             slot_addr, slot_data, e[16:8], e[7:0]);
                else n_pass++;
            end
        end
        if (frame_done) begin
            cnt_fd++;
            n_checks++;
            if (done_q.size() == 0) begin
                $display("FAIL frame_done_unexpected got slot_count=%0d expected none", slot_count);
            end else begin
                d = done_q.pop_front();
                if (slot_count !== d) $display("FAIL frame_done_count got %0d expected %0d", slot_count, d);
                else n_pass++;
            end
        end
        if (frame_start) cnt_fs++;
        if (err_framing) cnt_err++;
    end

    // Driver tasks
    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(b[i], BIT);
        line(stop_ok, BIT);
        line(1'b1, BIT + 2);
    endtask

    task automatic send_break(input int low_clks);
        line(1'b0, low_clks);
        line(1'b1, 12 * US);
    endtask

    task automatic push_slot(input int addr, input logic [7:0] data);
        exp_q.push_back({9'(addr), data});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({slot_we, slot_addr, slot_data, start_code, frame_start, frame_done, slot_count, err_framing} !== '0)
            $display("FAIL reset_outputs got we=%0b addr=%0d data=%02h sc=%02h cnt=%0d expected all 0",
                     slot_we, slot_addr, slot_data, start_code, slot_count);
        else n_pass++;
        rst_n = 1'b1;
        line(1'b1, 10);
    endtask

    task automatic test_basic_frame();
        int fs0 = cnt_fs;
        send_break(100 * US);
        send_byte(8'h00, 1'b1);
        push_slot(0, 8'h11); push_slot(1, 8'h22); push_slot(2, 8'h33);
        done_q.push_back(10'd3);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        n_checks++;
        if (slot_count !== 10'd3) $display("FAIL t1_slot_count got %0d expected 3", slot_count);
        else n_pass++;
        send_break(100 * US);
        n_checks++;
        if (cnt_fs - fs0 !== 1) $display("FAIL t1_frame_start got %0d expected 1", cnt_fs - fs0);
        else n_pass++;
        n_checks++;
        if (done_q.size() !== 0) $display("FAIL t1_frame_done got pending=%0d expected 0", done_q.size());
        else n_pass++;
        n_checks++;
        if ({slot_addr, slot_data} !== {9'd2, 8'h33})
            $display("FAIL t1_port_hold got addr=%0d data=%02h expected addr=2 data=33", slot_addr, slot_data);
        else n_pass++;
        n_checks++;
        if (slot_count !== 10'd0) $display("FAIL t1_count_cleared got %0d expected 0", slot_count);
        else n_pass++;
    endtask

    task automatic test_bad_start_code();
        int fs0 = cnt_fs;
        int we0 = cnt_we;
        int fd0 = cnt_fd;
        send_break(100 * US);
        send_byte(8'hCC, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        n_checks++;
        if (start_code !== 8'hCC) $display("FAIL t2_start_code got %02h expected cc", start_code);
        else n_pass++;
        n_checks++;
        if ((cnt_fs - fs0) + (cnt_we - we0) + (cnt_fd - fd0) !== 0)
            $display("FAIL t2_no_strobes got fs=%0d we=%0d fd=%0d expected 0", cnt_fs - fs0, cnt_we - we0, cnt_fd - fd0);
        else n_pass++;
    endtask

    task automatic test_short_break();
        int fs0 = cnt_fs;
        int we0 = cnt_we;
        send_break(80 * US);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        n_checks++;
        if ((cnt_fs - fs0) + (cnt_we - we0) !== 0)
            $display("FAIL t3_short_break got fs=%0d we=%0d expected 0", cnt_fs - fs0, cnt_we - we0);
        else n_pass++;
        n_checks++;
        if (start_code !== 8'hCC) $display("FAIL t3_start_code got %02h expected cc", start_code);
        else n_pass++;
    endtask

    task automatic test_framing_error();
        int we0 = cnt_we;
        int er0 = cnt_err;
        int fd0 = cnt_fd;
        send_break(100 * US);
        send_byte(8'h00, 1'b1);
        push_slot(0, 8'hA1); push_slot(1, 8'hA2);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b1);
        send_byte(8'hA5, 1'b1);
        n_checks++;
        if (cnt_err - er0 !== 1) $display("FAIL t4_err_framing got %0d expected 1", cnt_err - er0);
        else n_pass++;
        n_checks++;
        if (cnt_we - we0 !== 2) $display("FAIL t4_writes got %0d expected 2", cnt_we - we0);
        else n_pass++;
        send_break(100 * US);
        n_checks++;
        if (cnt_fd - fd0 !== 0) $display("FAIL t4_no_frame_done got %0d expected 0", cnt_fd - fd0);
        else n_pass++;
    endtask

    task automatic test_max_slots();
        int we0 = cnt_we;
        int fd0 = cnt_fd;
        logic [7:0] b;
        send_break(100 * US);
        send_byte(8'h00, 1'b1);
        done_q.push_back(10'd512);
        for (int i = 0; i < 513; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 512) push_slot(i, b);
            send_byte(b, 1'b1);
        end
        n_checks++;
        if (cnt_we - we0 !== 512) $display("FAIL t5_writes got %0d expected 512", cnt_we - we0);
        else n_pass++;
        n_checks++;
        if (cnt_fd - fd0 !== 1) $display("FAIL t5_frame_done got %0d expected 1", cnt_fd - fd0);
        else n_pass++;
        n_checks++;
        if (slot_count !== 10'd512) $display("FAIL t5_slot_count got %0d expected 512", slot_count);
        else n_pass++;
    endtask

    task automatic test_enable();
        int we0 = cnt_we;
        int fd0 = cnt_fd;
        send_break(100 * US);
        send_byte(8'h00, 1'b1);
        push_slot(0, 8'h77);
        send_byte(8'h77, 1'b1);
        line(1'b0, BIT);
        line(1'b1, BIT);
        enable = 1'b0;
        line(1'b0, 2 * BIT);
        enable = 1'b1;
        line(1'b1, 6 * BIT);
        send_byte(8'h99, 1'b1);
        send_break(100 * US);
        n_checks++;
        if (cnt_we - we0 !== 1) $display("FAIL en_writes got %0d expected 1", cnt_we - we0);
        else n_pass++;
        n_checks++;
        if (cnt_fd - fd0 !== 0) $display("FAIL en_no_frame_done got %0d expected 0", cnt_fd - fd0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_slot();
        int we0;
        send_break(100 * US);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_slot(i, 8'(8'h10 + i));
            send_byte(8'(8'h10 + i), 1'b1);
        end
        line(1'b0, BIT);
        line(1'b1, BIT);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({slot_we, slot_addr, slot_data, start_code, frame_start, frame_done, slot_count, err_framing} !== '0)
            $display("FAIL t6_reset_outputs got addr=%0d data=%02h cnt=%0d expected all 0", slot_addr, slot_data, slot_count);
        else n_pass++;
        line(1'b0, 2 * BIT);
        rst_n = 1'b1;
        we0 = cnt_we;
        line(1'b1, 5 * BIT);
        send_byte(8'h44, 1'b1);
        send_byte(8'h00, 1'b1);
        n_checks++;
        if (cnt_we - we0 !== 0) $display("FAIL t6_no_write_after_reset got %0d expected 0", cnt_we - we0);
        else n_pass++;
        send_break(100 * US);
        send_byte(8'h00, 1'b1);
        push_slot(0, 8'h5A); push_slot(1, 8'hA5);
        done_q.push_back(10'd2);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_break(100 * US);
        n_checks++;
        if (cnt_we - we0 !== 2) $display("FAIL t6_new_frame_writes got %0d expected 2", cnt_we - we0);
        else n_pass++;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_basic_frame();
        test_bad_start_code();
        test_short_break();
        test_framing_error();
        test_max_slots();
        test_enable();
        test_reset_mid_slot();
        line(1'b1, 20);
        n_checks++;
        if (exp_q.size() + done_q.size() !== 0)
            $display("FAIL scoreboard_drain got writes=%0d dones=%0d pending expected 0", exp_q.size(), done_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
